// File: rtl/shift_sequencer.sv
// ============================================================================
// Module   : shift_sequencer
// Purpose  : Sequences repeated one-hot control pulses to an external register.
// Revision : 1.0
// ============================================================================
`default_nettype none

module shift_sequencer #(
   parameter int DATA_WIDTH = 16,
   parameter int CNT_WIDTH  = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   // command side
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [2:0]            cmd_op,
   input  logic [CNT_WIDTH-1:0]  cmd_cnt,
   input  logic [DATA_WIDTH-1:0] cmd_data,
   input  logic                  cmd_fill,
   input  logic                  abort,
   // register side
   input  logic [DATA_WIDTH-1:0] reg_q,
   output logic                  cl,
   output logic                  ld,
   output logic                  inc,
   output logic                  dec,
   output logic                  sr,
   output logic                  sl,
   output logic                  ir,
   output logic                  il,
   output logic [DATA_WIDTH-1:0] data,
   // status
   output logic                  busy,
   output logic                  done
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [2:0] c_OP_CLR  = 3'd0;
   localparam logic [2:0] c_OP_LOAD = 3'd1;
   localparam logic [2:0] c_OP_INC  = 3'd2;
   localparam logic [2:0] c_OP_DEC  = 3'd3;
   localparam logic [2:0] c_OP_SHR  = 3'd4;
   localparam logic [2:0] c_OP_SHL  = 3'd5;
   localparam logic [2:0] c_OP_ROR  = 3'd6;
   localparam logic [2:0] c_OP_ROL  = 3'd7;

   localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = CNT_WIDTH'(1);

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [2:0]              r_op;
   logic [CNT_WIDTH-1:0]    r_cnt;
   logic [DATA_WIDTH-1:0]   r_data;
   logic                    r_fill;
   logic [CNT_WIDTH-1:0]    w_load_cnt;
   logic                    w_accept;
   logic                    w_unused_reg_bits;

   // CLR and LOAD always run for one cycle; the repeat count only applies to ops 2-7
   assign w_load_cnt = ((cmd_op == c_OP_CLR) || (cmd_op == c_OP_LOAD)) ? c_CNT_ONE : cmd_cnt;
   assign w_accept   = cmd_valid && cmd_ready;

   assign w_unused_reg_bits = ^reg_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_op    <= 3'd0;
         r_cnt   <= '0;
         r_data  <= '0;
         r_fill  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_op   <= cmd_op;
            r_cnt  <= w_load_cnt;
            r_data <= cmd_data;
            r_fill <= cmd_fill;
         end else if (r_state == S_EXEC) begin
            r_cnt <= r_cnt - c_CNT_ONE;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      cmd_ready   = 1'b0;
      busy        = 1'b1;
      done        = 1'b0;
      cl          = 1'b0;
      ld          = 1'b0;
      inc         = 1'b0;
      dec         = 1'b0;
      sr          = 1'b0;
      sl          = 1'b0;
      ir          = 1'b0;
      il          = 1'b0;
      data        = '0;

      case (r_state)
         S_IDLE: begin
            cmd_ready = 1'b1;
            busy      = 1'b0;
            if (cmd_valid) begin
               w_state_nxt = (w_load_cnt == '0) ? S_DONE : S_EXEC;
            end
         end

         S_EXEC: begin
            // serial inputs read reg_q live so each rotate step sees the prior step's result
            case (r_op)
               c_OP_SHR: ir = r_fill;
               c_OP_ROR: ir = reg_q[0];
               c_OP_SHL: il = r_fill;
               c_OP_ROL: il = reg_q[DATA_WIDTH-1];
               default: ;
            endcase
            if (r_op == c_OP_LOAD) begin
               data = r_data;
            end

            if (abort) begin
               // the abort cycle itself is the completion cycle: pulse done, no control
               done        = 1'b1;
               w_state_nxt = S_IDLE;
            end else begin
               case (r_op)
                  c_OP_CLR:           cl  = 1'b1;
                  c_OP_LOAD:          ld  = 1'b1;
                  c_OP_INC:           inc = 1'b1;
                  c_OP_DEC:           dec = 1'b1;
                  c_OP_SHR, c_OP_ROR: sr  = 1'b1;
                  c_OP_SHL, c_OP_ROL: sl  = 1'b1;
                  default: ;
               endcase
               if (r_cnt == c_CNT_ONE) begin
                  w_state_nxt = S_DONE;
               end
            end
         end

         S_DONE: begin
            done        = 1'b1;
            w_state_nxt = S_IDLE;
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_shift_sequencer.sv
// ============================================================================
// Module   : tb_shift_sequencer
// Purpose  : Directed and randomized checks of shift_sequencer against a model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_shift_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [2:0]  cmd_op;
   logic [3:0]  cmd_cnt;
   logic [15:0] cmd_data;
   logic        cmd_fill;
   logic        abort;
   logic [15:0] reg_q = 16'h0000;
   logic        cl, ld, inc, dec, sr, sl, ir, il;
   logic [15:0] data;
   logic        busy, done;

   int n_checks = 0;
   int n_fail   = 0;

   shift_sequencer #(.DATA_WIDTH(16), .CNT_WIDTH(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_cnt   (cmd_cnt),
      .cmd_data  (cmd_data),
      .cmd_fill  (cmd_fill),
      .abort     (abort),
      .reg_q     (reg_q),
      .cl        (cl),
      .ld        (ld),
      .inc       (inc),
      .dec       (dec),
      .sr        (sr),
      .sl        (sl),
      .ir        (ir),
      .il        (il),
      .data      (data),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   // the controlled register
   always @(posedge clk) begin
      if (cl)       reg_q <= 16'h0000;
      else if (ld)  reg_q <= data;
      else if (inc) reg_q <= reg_q + 16'd1;
      else if (dec) reg_q <= reg_q - 16'd1;
      else if (sr)  reg_q <= {ir, reg_q[15:1]};
      else if (sl)  reg_q <= {reg_q[14:0], il};
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [5:0] ctrl_of(input logic [2:0] op);
      case (op)
         3'd0:       return 6'b100000;
         3'd1:       return 6'b010000;
         3'd2:       return 6'b001000;
         3'd3:       return 6'b000100;
         3'd4, 3'd6: return 6'b000010;
         default:    return 6'b000001;
      endcase
   endfunction

   // register value after n steps of op, computed in one shot
   function automatic logic [15:0] model_reg(input logic [2:0] op, input logic [15:0] r0,
                                             input int n, input logic [15:0] d, input logic fill);
      logic [15:0] ones;
      int          k;
      ones = 16'hFFFF;
      k    = n % 16;
      if (n == 0) return r0;
      case (op)
         3'd0: return 16'h0000;
         3'd1: return d;
         3'd2: return r0 + 16'(n);
         3'd3: return r0 - 16'(n);
         3'd4: return (r0 >> n) | (fill ? ~(ones >> n) : 16'h0000);
         3'd5: return (r0 << n) | (fill ? ~(ones << n) : 16'h0000);
         3'd6: return (k == 0) ? r0 : ((r0 >> k) | (r0 << (16 - k)));
         default: return (k == 0) ? r0 : ((r0 << k) | (r0 >> (16 - k)));
      endcase
   endfunction

   // rst_at / abort_at: cycle number (1-based after acceptance) or 0 for none
   task automatic run_cmd(input logic [2:0] op, input logic [3:0] cnt, input logic [15:0] d,
                          input logic fill, input int abort_at, input int rst_at,
                          input bit hold, input bit abort_late);
      int          n, pulses, done_cyc, idle_cyc, j;
      bit          by_rst, by_abort;
      logic [15:0] r0;
      logic        e_ir, e_il;
      logic [15:0] e_data;

      @(negedge clk);
      #1;
      check_eq("ready_before_cmd", cmd_ready, 1);
      r0        = reg_q;
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_cnt   = cnt;
      cmd_data  = d;
      cmd_fill  = fill;

      n        = (op <= 3'd1) ? 1 : int'(cnt);
      by_rst   = (rst_at > 0) && (rst_at <= n);
      by_abort = !by_rst && (abort_at > 0) && (abort_at <= n);
      pulses   = by_rst ? rst_at : (by_abort ? abort_at - 1 : n);
      done_cyc = by_rst ? -1 : (by_abort ? abort_at : n + 1);
      idle_cyc = by_rst ? rst_at + 1 : done_cyc + 1;

      for (int k = 1; k <= idle_cyc; k++) begin
         @(negedge clk);
         cmd_valid = hold && (k < idle_cyc);
         if (hold) begin
            cmd_op   = 3'($urandom);
            cmd_cnt  = 4'($urandom);
            cmd_data = 16'($urandom);
            cmd_fill = 1'($urandom);
         end
         abort = (by_abort && k == abort_at) ||
                 (abort_late && !by_abort && !by_rst && k == done_cyc);
         rst_n = !(by_rst && k == rst_at);
         #1;
         if (k <= pulses) begin
            j      = k - 1;
            e_ir   = (op == 3'd4) ? fill : ((op == 3'd6) ? r0[j % 16] : 1'b0);
            e_il   = (op == 3'd5) ? fill : ((op == 3'd7) ? r0[(31 - j) % 16] : 1'b0);
            e_data = (op == 3'd1) ? d : 16'h0000;
            check_eq("ctrl_pulse", {cl, ld, inc, dec, sr, sl}, ctrl_of(op));
            check_eq("ir_pulse", ir, e_ir);
            check_eq("il_pulse", il, e_il);
            check_eq("data_pulse", data, e_data);
            check_eq("status_exec", {busy, done, cmd_ready}, 3'b100);
         end else if (k == done_cyc) begin
            check_eq("ctrl_done", {cl, ld, inc, dec, sr, sl}, 6'b0);
            check_eq("status_done", {busy, done, cmd_ready}, 3'b110);
         end else if (k == idle_cyc) begin
            check_eq("ctrl_idle", {cl, ld, inc, dec, sr, sl, ir, il}, 8'b0);
            check_eq("data_idle", data, 16'h0000);
            check_eq("status_idle", {busy, done, cmd_ready}, 3'b001);
            check_eq("reg_final", reg_q, model_reg(op, r0, pulses, d, fill));
         end
      end
      cmd_valid = 1'b0;
      abort     = 1'b0;
      rst_n     = 1'b1;
   endtask

   initial begin
      int n, mode, ab, rs;
      logic [2:0] op;
      logic [3:0] cnt;

      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_op    = 3'd0;
      cmd_cnt   = 4'd0;
      cmd_data  = 16'h0000;
      cmd_fill  = 1'b0;
      abort     = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_eq("reset_status", {busy, done, cmd_ready}, 3'b001);
      check_eq("reset_ctrl", {cl, ld, inc, dec, sr, sl, ir, il}, 8'b0);
      check_eq("reset_data", data, 16'h0000);

      run_cmd(3'd1, 4'd0, 16'hA5A5, 1'b0, 0, 0, 1'b0, 1'b0);   // LOAD A5A5
      run_cmd(3'd0, 4'd5, 16'h1234, 1'b0, 0, 0, 1'b0, 1'b0);   // CLR
      run_cmd(3'd4, 4'd3, 16'h0000, 1'b1, 0, 0, 1'b0, 1'b0);   // SHR 3, fill 1 -> E000
      check_eq("shr_e000", reg_q, 16'hE000);
      run_cmd(3'd1, 4'd0, 16'h8001, 1'b0, 0, 0, 1'b0, 1'b0);
      run_cmd(3'd7, 4'd2, 16'h0000, 1'b0, 0, 0, 1'b0, 1'b0);   // ROL 2 -> 0006
      check_eq("rol_0006", reg_q, 16'h0006);
      run_cmd(3'd2, 4'd0, 16'h0000, 1'b0, 0, 0, 1'b0, 1'b0);   // INC 0
      run_cmd(3'd3, 4'd10, 16'h0000, 1'b0, 4, 0, 1'b0, 1'b0);  // DEC 10, abort in cycle 4
      run_cmd(3'd5, 4'd8, 16'h0000, 1'b1, 0, 2, 1'b1, 1'b0);   // SHL 8, reset in cycle 2
      run_cmd(3'd2, 4'd15, 16'h0000, 1'b0, 0, 0, 1'b0, 1'b1);  // INC max count
      run_cmd(3'd1, 4'd0, 16'h1357, 1'b0, 0, 0, 1'b0, 1'b0);
      run_cmd(3'd6, 4'd5, 16'h0000, 1'b0, 0, 0, 1'b1, 1'b0);   // ROR 5

      for (int i = 0; i < 60; i++) begin
         op   = 3'($urandom);
         cnt  = 4'($urandom);
         n    = (op <= 3'd1) ? 1 : int'(cnt);
         mode = int'($urandom_range(0, 9));
         ab   = 0;
         rs   = 0;
         if (n >= 1 && mode < 2)      ab = int'($urandom_range(1, n));
         else if (n >= 1 && mode < 4) rs = int'($urandom_range(1, n));
         run_cmd(op, cnt, 16'($urandom), 1'($urandom), ab, rs, 1'($urandom), 1'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
